// File: rtl/fp_pkg.sv
// Shared floating-point constants and classification type for the
// float-to-integer conversion path.
package fp_pkg;

    localparam int EXP_W    = 8;
    localparam int FRAC_W   = 23;
    localparam int EXP_BIAS = 127;

    localparam logic [EXP_W-1:0] EXP_MAX      = 8'd255;
    localparam logic [EXP_W-1:0] UINT_OVF_EXP = 8'd159;

    // Biased exponent at which the 24-bit significand is already an integer
    // (bias + fraction width); shifts are measured relative to this point.
    localparam logic [EXP_W-1:0] SHIFT_ZERO_EXP = 8'(EXP_BIAS + FRAC_W);

    // Right shifts beyond this leave only sticky information, so clamp here.
    localparam logic [5:0] RSHIFT_MAX = 6'd40;

    localparam logic [31:0] UINT_MAX = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_NORMAL,
        FP_INF,
        FP_NAN,
        FP_OVF
    } fp_class_t;

    // Classify a binary32 operand from its exponent and fraction fields.
    function automatic fp_class_t classify(input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
        fp_class_t c;
        if (e == '0)
            c = FP_ZERO;
        else if (e == EXP_MAX)
            c = (f != '0) ? FP_NAN : FP_INF;
        else if (e >= UINT_OVF_EXP)
            c = FP_OVF;
        else
            c = FP_NORMAL;
        return c;
    endfunction

endpackage

// File: rtl/reg_32.sv
// Generic 32-bit register: synchronous active-high clear, load on write_en,
// otherwise hold. Reset takes priority over write_en.
module reg_32 (
    input  logic        clk,
    input  logic        write_en,
    input  logic        reset,
    input  logic [31:0] data_in,
    output logic [31:0] data_out
);

    // Clear on reset, load when enabled, hold otherwise.
    always_ff @(posedge clk) begin
        if (reset)
            data_out <= 32'h0;
        else if (write_en)
            data_out <= data_in;
    end

endmodule

// File: rtl/fp32_to_uint32_pipe.sv
// Two-stage IEEE-754 binary32 to uint32 converter.
// Stage 1 aligns the significand to an integer plus guard/sticky bits and
// resolves special cases into force-zero / force-max flags.
// Stage 2 rounds to nearest-even and saturates on carry-out.
// The pipeline has no enable: a new operand is accepted on every edge and its
// result appears on q two edges later.
module fp32_to_uint32_pipe
    import fp_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        areset,
    input  logic [31:0] a,
    output logic [31:0] q
);

    // Only a two-stage pipeline is implemented.
    if (LATENCY != 2) begin : g_bad_latency
        $error("fp32_to_uint32_pipe supports LATENCY == 2 only");
    end

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, align
    // ------------------------------------------------------------------
    logic              sign;
    logic [EXP_W-1:0]  exp_f;
    logic [FRAC_W-1:0] frac;
    logic [FRAC_W:0]   sig;
    fp_class_t         cls;

    assign sign  = a[31];
    assign exp_f = a[30:23];
    assign frac  = a[22:0];
    assign sig   = {1'b1, frac};
    assign cls   = classify(exp_f, frac);

    logic [31:0] s1_int;
    logic        s1_guard;
    logic        s1_sticky;
    logic [7:0]  lshift;
    logic [7:0]  rshift_full;
    logic [5:0]  rshift;
    logic [63:0] wide;

    // Align the significand: left shift when the exponent is at or above the
    // integer point, otherwise right shift keeping guard and sticky bits.
    always_comb begin
        s1_int      = 32'h0;
        s1_guard    = 1'b0;
        s1_sticky   = 1'b0;
        lshift      = 8'h0;
        rshift_full = 8'h0;
        rshift      = 6'h0;
        wide        = 64'h0;
        if (exp_f >= SHIFT_ZERO_EXP) begin
            // Normal values here need at most 8 positions; larger exponents
            // are overridden by the overflow/inf flags.
            lshift = exp_f - SHIFT_ZERO_EXP;
            s1_int = 32'(sig) << lshift;
        end else begin
            rshift_full = SHIFT_ZERO_EXP - exp_f;
            rshift      = (rshift_full > 8'(RSHIFT_MAX)) ? RSHIFT_MAX : rshift_full[5:0];
            wide        = {sig, 40'h0} >> rshift;
            s1_int      = {8'h0, wide[63:40]};
            s1_guard    = wide[39];
            s1_sticky   = |wide[38:0];
        end
    end

    logic s1_force_zero;
    logic s1_force_max;

    // Any negative operand, zero/denormal or NaN yields 0; positive infinity
    // or magnitude >= 2^32 yields the saturated maximum.
    always_comb begin
        s1_force_zero = sign || (cls == FP_ZERO) || (cls == FP_NAN);
        s1_force_max  = !sign && ((cls == FP_INF) || (cls == FP_OVF));
    end

    logic [31:0] s1_flags_d;
    logic [31:0] s1_int_q;
    logic [31:0] s1_flags_q;

    assign s1_flags_d = {28'h0, s1_guard, s1_sticky, s1_force_zero, s1_force_max};

    reg_32 u_s1_int (
        .clk      (clk),
        .write_en (1'b1),
        .reset    (areset),
        .data_in  (s1_int),
        .data_out (s1_int_q)
    );

    reg_32 u_s1_flags (
        .clk      (clk),
        .write_en (1'b1),
        .reset    (areset),
        .data_in  (s1_flags_d),
        .data_out (s1_flags_q)
    );

    // ------------------------------------------------------------------
    // Stage 2: round to nearest even, saturate
    // ------------------------------------------------------------------
    logic        s2_guard;
    logic        s2_sticky;
    logic        s2_force_zero;
    logic        s2_force_max;
    logic        unused_flag_bits;

    assign s2_guard         = s1_flags_q[3];
    assign s2_sticky        = s1_flags_q[2];
    assign s2_force_zero    = s1_flags_q[1];
    assign s2_force_max     = s1_flags_q[0];
    assign unused_flag_bits = &{1'b0, s1_flags_q[31:4]};

    logic        round_up;
    logic [32:0] rounded;
    logic [31:0] s2_result;

    // Increment on guard when the discarded part is above half or exactly
    // half with an odd integer; a carry out of 32 bits saturates.
    always_comb begin
        round_up  = s2_guard && (s2_sticky || s1_int_q[0]);
        rounded   = {1'b0, s1_int_q} + {32'h0, round_up};
        s2_result = rounded[31:0];
        if (s2_force_zero)
            s2_result = 32'h0;
        else if (s2_force_max || rounded[32])
            s2_result = UINT_MAX;
    end

    reg_32 u_s2_result (
        .clk      (clk),
        .write_en (1'b1),
        .reset    (areset),
        .data_in  (s2_result),
        .data_out (q)
    );

endmodule

// File: tb/tb_fp32_to_uint32_pipe.sv
// Bench for fp32_to_uint32_pipe: directed and random operands scored against
// a real-arithmetic reference, a mid-stream reset, and a reg_32 unit check.
module tb_fp32_to_uint32_pipe;

    logic        clk = 1'b0;
    logic        areset;
    logic [31:0] a;
    logic [31:0] q;

    logic        r_we;
    logic        r_rst;
    logic [31:0] r_din;
    logic [31:0] r_dout;

    int total = 0;
    int bad   = 0;
    int edge_cnt = 0;

    logic [31:0] exp_q[$];
    int          tag_q[$];

    fp32_to_uint32_pipe #(.LATENCY(2)) dut (
        .clk    (clk),
        .areset (areset),
        .a      (a),
        .q      (q)
    );

    reg_32 u_reg (
        .clk      (clk),
        .write_en (r_we),
        .reset    (r_rst),
        .data_in  (r_din),
        .data_out (r_dout)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (edge %0d)", name, act, req, edge_cnt);
        end
    endtask

    // Reference: value of the float computed with real arithmetic, then
    // rounded half-to-even and clamped to the uint32 range.
    function automatic logic [31:0] ref_conv(input logic [31:0] x);
        int     e;
        int     f;
        real    v;
        real    fl;
        real    diff;
        longint n;
        e = int'(x[30:23]);
        f = int'(x[22:0]);
        if (e == 255 && f != 0) return 32'h0;
        if (x[31]) return 32'h0;
        if (e == 255) return 32'hFFFF_FFFF;
        if (e == 0)
            v = real'(f) * (2.0 ** (-149));
        else
            v = (8388608.0 + real'(f)) * (2.0 ** (e - 150));
        if (v >= 4294967296.0) return 32'hFFFF_FFFF;
        fl   = $floor(v);
        diff = v - fl;
        n    = longint'(fl);
        if (diff > 0.5 || (diff == 0.5 && n[0])) n++;
        if (n >= 64'sd4294967296) return 32'hFFFF_FFFF;
        return n[31:0];
    endfunction

    // Driver: present one operand before the next rising edge and queue its
    // expected result for the edge after that. A reset edge also zeroes the
    // result that would have emerged at that same edge.
    task automatic drive(input logic [31:0] val, input logic rst);
        @(negedge clk);
        a      = val;
        areset = rst;
        if (rst && tag_q.size() > 0 && tag_q[$] == edge_cnt + 1)
            exp_q[$] = 32'h0;
        exp_q.push_back(rst ? 32'h0 : ref_conv(val));
        tag_q.push_back(edge_cnt + 2);
    endtask

    // Monitor: after each rising edge compare q against the queued result
    // targeted at this edge.
    always @(posedge clk) begin
        #1;
        edge_cnt++;
        while (tag_q.size() > 0 && tag_q[0] <= edge_cnt) begin
            if (tag_q[0] < edge_cnt)
                check("q_missed", q, exp_q[0]);
            else
                check("q", q, exp_q[0]);
            void'(exp_q.pop_front());
            void'(tag_q.pop_front());
        end
    end

    logic [31:0] directed[] = '{
        32'h3F80_0000, 32'h4420_0000, 32'h43F0_0000,
        32'h4020_0000, 32'h4060_0000, 32'h3FC0_0000, 32'h3F00_0000,
        32'h3F40_0000, 32'h4019_999A,
        32'hBF80_0000, 32'hBECC_CCCD, 32'h8000_0000, 32'h0000_0001, 32'h0000_0000,
        32'h4F7F_FFFF, 32'h4F80_0000, 32'h7F80_0000, 32'h7FC0_0000, 32'hFF80_0000,
        32'h4F7F_FFFF, 32'h3F00_0001, 32'h3EFF_FFFF, 32'h4B7F_FFFF, 32'h4B00_0001
    };

    initial begin
        logic [31:0] hold_val;
        a      = 32'h0;
        areset = 1'b1;
        r_we   = 1'b0;
        r_rst  = 1'b1;
        r_din  = 32'h0;

        // Reset state
        repeat (3) drive($urandom, 1'b1);

        // Directed operands, back to back
        foreach (directed[i]) drive(directed[i], 1'b0);

        // Raw random bit patterns
        repeat (300) drive($urandom, 1'b0);

        // Random values concentrated around the representable uint32 range,
        // with an occasional single-cycle reset
        repeat (400) begin
            logic [31:0] v;
            v = {1'($urandom_range(0, 7) == 0), 8'($urandom_range(118, 162)), 23'($urandom)};
            if ($urandom_range(0, 5) == 0) v[15:0] = 16'h0;
            drive(v, $urandom_range(0, 60) == 0);
        end

        // Mid-stream reset on a constant 640.0 stream
        repeat (4) drive(32'h4420_0000, 1'b0);
        drive(32'h4420_0000, 1'b1);
        repeat (5) drive(32'h4420_0000, 1'b0);

        // Drain with a bounded wait
        repeat (10) begin
            if (exp_q.size() > 0) @(negedge clk);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got=%0d pending expected=0", exp_q.size());
        end

        // reg_32 unit: reset, load, hold, load, reset-over-write
        @(negedge clk);
        r_rst = 1'b1; r_we = 1'b0; r_din = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        check("reg_reset", r_dout, 32'h0);
        @(negedge clk);
        r_rst = 1'b0; r_we = 1'b1; r_din = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        check("reg_load_deadbeef", r_dout, 32'hDEAD_BEEF);
        hold_val = 32'hDEAD_BEEF;
        repeat (5) begin
            @(negedge clk);
            r_we = 1'b0; r_din = $urandom;
            @(posedge clk); #1;
            check("reg_hold", r_dout, hold_val);
        end
        @(negedge clk);
        r_we = 1'b1; r_din = 32'h1234_5678;
        @(posedge clk); #1;
        check("reg_load_12345678", r_dout, 32'h1234_5678);
        @(negedge clk);
        r_we = 1'b1; r_rst = 1'b1; r_din = 32'hCAFE_F00D;
        @(posedge clk); #1;
        check("reg_reset_wins", r_dout, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp32_to_uint32_pipe.md
Name: fp32_to_uint32_pipe

Overview:
- Pipelined converter from IEEE-754 single-precision float to 32-bit unsigned integer.
- Used by the rasterizer to turn raster-space vertex coordinates into integer pixel positions.
- Fixed 2-cycle latency and accepts one new operand every clock.
- Pipeline stages are built from a generic 32-bit enabled register.

Parameters:
- LATENCY, 2: clocks from operand `a` to result `q`. Fixed; any other value is unsupported.

Ports:
- `clk`: input, 1 bit. Single clock, rising edge.
- `areset`: input, 1 bit. Reset; synchronous, active-high.
- `a`: input, 32 bits. IEEE-754 binary32 operand, sampled every rising edge.
- `q`: output, 32 bits. Unsigned integer result for the operand sampled 2 edges earlier.

Behaviour:
- Clock and reset:
  - One clock `clk`.
  - Reset is synchronous and active-high: when `areset`=1 at a rising edge, all pipeline registers load 0.
  - While reset is held, and for the first 2 edges after its release, `q`=0x00000000.
  - No enable and no valid handshake; the pipeline always advances.
- Timing:
  - Operand presented before edge N produces its result on `q` after edge N+1, i.e. stable during cycle N+2.
  - Consumers write `q` exactly 2 cycles after driving `a`.
  - Throughput is 1 operand/clock; back-to-back operands never interfere.
- Stage 1 (registered at edge N):
  - Unpack sign s, exponent e (8 bits), fraction f (23 bits).
  - Classify: zero/denormal (e=0), NaN (e=255, f≠0), infinity (e=255, f=0), overflow (e≥159, i.e. unbiased ≥32), normal.
  - Form significand {1,f}.
  - Shift it by (e−150): left if ≥0, right otherwise.
  - Keep the 32-bit integer part plus guard bit and sticky bit (OR of all lower shifted-out bits).
- Stage 2 (registered at edge N+1):
  - Round to nearest, ties to even: increment if guard and (sticky or LSB).
  - Saturate if the increment carries out of 32 bits.
- Special-case results:
  - s=1 with any magnitude (including −0, −inf, and negatives that round to 0): `q`=0.
  - e=0 (zero/denormal): `q`=0.
  - NaN: `q`=0.
  - +inf, or positive value ≥ 2^32 (including after rounding): `q`=0xFFFFFFFF.
  - Values in (0, 0.5]: `q`=0; 0.5 ties to even gives 0.
- Reset mid-stream: in-flight results are discarded, not delivered late, and `q` reads 0 from the edge after reset asserts.
- Arithmetic: all internal paths unsigned; shift distance clamped to 0..40 on the right side; no latches; no X on `q` after reset.

Decomposition:
- Shared package `fp_pkg`:
  - EXP_W=8, FRAC_W=23, EXP_BIAS=127.
  - EXP_MAX=255, UINT_OVF_EXP=159.
  - UINT_MAX=32'hFFFF_FFFF.
  - Enum `fp_class_t` {FP_ZERO, FP_NORMAL, FP_INF, FP_NAN, FP_OVF}.
- One sub-module, `reg_32`:
  - Ports: `clk`, `write_en`, `reset`, `data_in`[31:0], `data_out`[31:0].
  - Synchronous active-high clear to 0, load on `write_en`, otherwise hold.
  - Instantiated with `write_en` tied 1 for the stage-1 integer/flags and the stage-2 result.
  - The same `reg_32` serves the rasterizer's coordinate and bounds registers.

Test Plan:
- Basic integers: `a`=0x3F800000 (1.0), 0x44200000 (640.0), 0x43F00000 (480.0) on consecutive clocks → `q`=1, 640, 480 on the 3 cycles starting 2 clocks later; confirms latency 2 and throughput 1.
- Rounding: 0x40200000 (2.5) → 2; 0x40600000 (3.5) → 4; 0x3FC00000 (1.5) → 2; 0x3F000000 (0.5) → 0; 0x3F400000 (0.75) → 1; 0x4019999A (2.4) → 2.
- Negatives and zeros: 0xBF800000 (−1.0) → 0; 0xBECCCCCD (−0.4) → 0; 0x80000000 → 0; 0x00000001 (denormal) → 0; 0x00000000 → 0.
- Range limits: 0x4F7FFFFF → 0xFFFFFF00; 0x4F800000 (2^32) → 0xFFFFFFFF; 0x7F800000 (+inf) → 0xFFFFFFFF; 0x7FC00000 (NaN) → 0; 0xFF800000 (−inf) → 0.
- Reset: stream 0x44200000 every clock, then assert `areset` for 1 clock → `q`=0 from the edge after assertion and for 2 edges after release, then 640 resumes.
- `reg_32` unit: `write_en`=0 holds 0xDEADBEEF across 5 clocks; `write_en`=1 loads 0x12345678 next edge; `reset`=1 together with `write_en`=1 → 0 (reset wins).
